// File: rtl/regs_dump_if.sv
// Handshake bundle between the register-dump reader, the register-file read port
// and the downstream word consumer.
interface regs_dump_if #(
    parameter int XLEN = 64
);
    logic            start;
    logic            abort;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_data;
    logic            out_valid;
    logic            out_ready;
    logic [4:0]      out_idx;
    logic [XLEN-1:0] out_data;
    logic            busy;
    logic            freeze;
    logic            done;

    modport master (
        input  start, abort, rd_data, out_ready,
        output rd_addr, out_valid, out_idx, out_data, busy, freeze, done
    );

    modport slave (
        output start, abort, rd_data, out_ready,
        input  rd_addr, out_valid, out_idx, out_data, busy, freeze, done
    );
endinterface

// File: rtl/regs_dump_reader.sv
// Walks registers FIRST_REG..LAST_REG through a spare read port and streams
// {index, value} words over valid/ready, freezing the core while it runs.
module regs_dump_reader #(
    parameter int XLEN      = 64,
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic           clk,
    input  logic           rst,
    regs_dump_if.master    dump
);
    localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
    localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_HOLD   = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    state_t          state_r;
    logic [4:0]      idx_r;
    logic            out_valid_r;
    logic [4:0]      out_idx_r;
    logic [XLEN-1:0] out_data_r;
    logic            busy_r;
    logic            done_r;
    logic [4:0]      rd_addr_s;

    // Read-port address decode; depends only on state and index.
    always_comb begin
        rd_addr_s = FIRST_IDX;
        case (state_r)
            ST_IDLE:                     rd_addr_s = FIRST_IDX;
            ST_READ, ST_HOLD, ST_FINISH: rd_addr_s = idx_r;
            default:                     rd_addr_s = FIRST_IDX;
        endcase
    end

    // Dump sequencer with registered outputs; abort takes priority over the handshake.
    always_ff @(posedge clk) begin
        if (rst == 1'b0) begin
            state_r     <= ST_IDLE;
            idx_r       <= FIRST_IDX;
            out_valid_r <= 1'b0;
            out_idx_r   <= 5'd0;
            out_data_r  <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (dump.start) begin
                        idx_r   <= FIRST_IDX;
                        busy_r  <= 1'b1;
                        state_r <= ST_READ;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    if (dump.abort) begin
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        out_data_r  <= dump.rd_data;
                        out_idx_r   <= idx_r;
                        out_valid_r <= 1'b1;
                        state_r     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (dump.abort) begin
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else if (dump.out_ready) begin
                        out_valid_r <= 1'b0;
                        // LAST_REG is terminal, so the index never wraps.
                        if (idx_r != LAST_IDX) begin
                            idx_r   <= idx_r + 5'd1;
                            state_r <= ST_READ;
                        end else begin
                            done_r  <= 1'b1;
                            state_r <= ST_FINISH;
                        end
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                ST_FINISH: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign dump.rd_addr   = rd_addr_s;
    assign dump.out_valid = out_valid_r;
    assign dump.out_idx   = out_idx_r;
    assign dump.out_data  = out_data_r;
    assign dump.busy      = busy_r;
    assign dump.freeze    = busy_r;
    assign dump.done      = done_r;
endmodule

// File: tb/tb_regs_dump_reader.sv
// Directed and randomized checks of regs_dump_reader against a word-queue model
// built from a snapshot of the bench-owned register file.
module tb_regs_dump_reader;
    typedef struct {
        logic [4:0]  idx;
        logic [63:0] data;
    } word_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] regs [32];
    int          n_assert = 0;
    int          n_fail   = 0;

    regs_dump_if #(.XLEN(64)) ifa ();
    regs_dump_if #(.XLEN(64)) ifb ();

    regs_dump_reader #(.XLEN(64), .FIRST_REG(0), .LAST_REG(31)) dut_a (
        .clk(clk), .rst(rst), .dump(ifa)
    );
    regs_dump_reader #(.XLEN(64), .FIRST_REG(10), .LAST_REG(12)) dut_b (
        .clk(clk), .rst(rst), .dump(ifb)
    );

    assign ifa.rd_data = (ifa.rd_addr == 5'd0) ? 64'd0 : regs[ifa.rd_addr];
    assign ifb.rd_data = (ifb.rd_addr == 5'd0) ? 64'd0 : regs[ifb.rd_addr];

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input bit sel, input bit st, input bit ab, input bit rdy);
        if (sel) begin
            ifb.start = st; ifb.abort = ab; ifb.out_ready = rdy;
        end else begin
            ifa.start = st; ifa.abort = ab; ifa.out_ready = rdy;
        end
    endtask

    // mode 0: ready always high, 1: stall 5 cycles on idx 7, 2: random ready
    task automatic run_dump(input bit sel, input int mode, input bit do_write);
        word_t       q[$];
        int          first, last, nwords, stall_cnt, last_hs;
        bit          r, vld, dn, bs, fz, finished;
        logic [4:0]  oi;
        logic [63:0] od, x5_old;
        first = sel ? 10 : 0;
        last  = sel ? 12 : 31;
        for (int i = first; i <= last; i++)
            q.push_back('{5'(i), (i == 0) ? 64'd0 : regs[i]});
        nwords = q.size();
        x5_old = regs[5];
        stall_cnt = 0;
        last_hs = -10;
        finished = 1'b0;
        r = 1'b1;
        set_in(sel, 1'b1, 1'b0, 1'b1);
        tick();
        for (int j = 1; j < 600 && !finished; j++) begin
            vld = sel ? ifb.out_valid : ifa.out_valid;
            oi  = sel ? ifb.out_idx   : ifa.out_idx;
            od  = sel ? ifb.out_data  : ifa.out_data;
            dn  = sel ? ifb.done      : ifa.done;
            bs  = sel ? ifb.busy      : ifa.busy;
            fz  = sel ? ifb.freeze    : ifa.freeze;
            chk("busy_during", {63'd0, bs}, 64'd1);
            chk("freeze_during", {63'd0, fz}, 64'd1);
            chk("done", {63'd0, dn}, {63'd0, (j == last_hs + 1)});
            if (mode == 0)
                chk("valid_cadence", {63'd0, vld},
                    {63'd0, (j >= 2 && j % 2 == 0 && j <= 2 * nwords)});
            if (vld) begin
                if (q.size() == 0) begin
                    chk("extra_word", {63'd0, vld}, 64'd0);
                end else begin
                    chk("out_idx", {59'd0, oi}, {59'd0, q[0].idx});
                    chk("out_data", od, q[0].data);
                end
            end
            if (mode == 1) begin
                if (vld && oi == 5'd7 && stall_cnt < 5) begin
                    r = 1'b0;
                    stall_cnt++;
                end else begin
                    r = 1'b1;
                end
            end else if (mode == 2) begin
                r = 1'($urandom_range(0, 1));
            end else begin
                r = 1'b1;
            end
            set_in(sel, (j == 3), 1'b0, r);
            if (vld && r && q.size() != 0) begin
                void'(q.pop_front());
                if (q.size() == 0) last_hs = j;
            end
            if (q.size() == 0 && j == last_hs + 1) finished = 1'b1;
            if (do_write && j == 2) begin
                @(negedge clk);
                if (!(sel ? ifb.freeze : ifa.freeze)) regs[5] = 64'hDEAD_BEEF_0000_0005;
            end
            tick();
        end
        chk("dump_timeout", {63'd0, finished}, 64'd1);
        chk("busy_after", {63'd0, (sel ? ifb.busy : ifa.busy)}, 64'd0);
        chk("freeze_after", {63'd0, (sel ? ifb.freeze : ifa.freeze)}, 64'd0);
        chk("done_after", {63'd0, (sel ? ifb.done : ifa.done)}, 64'd0);
        if (do_write) chk("x5_kept", regs[5], x5_old);
        set_in(sel, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        bit seen;
        for (int i = 0; i < 32; i++) regs[i] = 64'h1000 + 64'(i);
        regs[0] = 64'd0;
        set_in(1'b0, 1'b0, 1'b0, 1'b1);
        set_in(1'b1, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        tick();
        tick();
        chk("rst_valid", {63'd0, ifa.out_valid}, 64'd0);
        chk("rst_idx", {59'd0, ifa.out_idx}, 64'd0);
        chk("rst_data", ifa.out_data, 64'd0);
        chk("rst_done", {63'd0, ifa.done}, 64'd0);
        chk("rst_busy", {63'd0, ifa.busy}, 64'd0);
        chk("rst_freeze", {63'd0, ifa.freeze}, 64'd0);
        chk("rst_rd_addr_a", {59'd0, ifa.rd_addr}, 64'd0);
        chk("rst_rd_addr_b", {59'd0, ifb.rd_addr}, 64'd10);
        rst = 1'b1;
        tick();

        run_dump(1'b0, 0, 1'b0);
        run_dump(1'b0, 1, 1'b0);
        run_dump(1'b1, 0, 1'b0);

        for (int i = 1; i < 32; i++) regs[i] = {$urandom, $urandom};
        run_dump(1'b1, 2, 1'b0);

        // abort in HOLD of idx 4 with a simultaneous handshake
        set_in(1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b1);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (ifa.out_valid && ifa.out_idx == 5'd4) seen = 1'b1;
            else tick();
        end
        chk("abort_reach_idx4", {63'd0, seen}, 64'd1);
        set_in(1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b1);
        chk("abort_valid", {63'd0, ifa.out_valid}, 64'd0);
        chk("abort_busy", {63'd0, ifa.busy}, 64'd0);
        chk("abort_done", {63'd0, ifa.done}, 64'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("abort_no_done", {63'd0, ifa.done}, 64'd0);
            chk("abort_idle", {63'd0, ifa.busy}, 64'd0);
        end
        run_dump(1'b0, 2, 1'b0);

        // reset while holding idx 20
        set_in(1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b1);
        seen = 1'b0;
        for (int k = 0; k < 80 && !seen; k++) begin
            if (ifa.out_valid && ifa.out_idx == 5'd20) seen = 1'b1;
            else tick();
        end
        chk("rst_reach_idx20", {63'd0, seen}, 64'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("mid_rst_valid", {63'd0, ifa.out_valid}, 64'd0);
        chk("mid_rst_idx", {59'd0, ifa.out_idx}, 64'd0);
        chk("mid_rst_data", ifa.out_data, 64'd0);
        chk("mid_rst_done", {63'd0, ifa.done}, 64'd0);
        chk("mid_rst_busy", {63'd0, ifa.busy}, 64'd0);
        chk("mid_rst_freeze", {63'd0, ifa.freeze}, 64'd0);
        chk("mid_rst_rd_addr", {59'd0, ifa.rd_addr}, 64'd0);
        tick();
        chk("post_rst_done", {63'd0, ifa.done}, 64'd0);
        chk("post_rst_busy", {63'd0, ifa.busy}, 64'd0);

        run_dump(1'b0, 2, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
